// File: rtl/bus_bridge_n.sv
// bus_bridge_n: registered CPU-to-peripheral bridge with NUM_DEV mask/base
// address windows. It does one request/ack transaction at a time, lets slow
// devices insert wait states, gives up after TIMEOUT cycles, and reports an
// error for unmapped addresses.
module bus_bridge_n #(
  parameter int unsigned               NUM_DEV  = 4,
  parameter logic [32*NUM_DEV-1:0]     DEV_BASE = {32'h0000_7F20, 32'h0000_7F10,
                                                   32'h0000_7F00, 32'h0000_0000},
  parameter logic [32*NUM_DEV-1:0]     DEV_MASK = {32'hFFFF_FFF0, 32'hFFFF_FFF0,
                                                   32'hFFFF_FFF0, 32'hFFFF_C000},
  parameter int unsigned               TIMEOUT  = 16,
  parameter int unsigned               TO_W     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pr_req,
  input  logic [31:0]           pr_addr,
  input  logic [31:0]           pr_wd,
  input  logic [3:0]            pr_byteen,
  output logic [31:0]           pr_rd,
  output logic                  pr_ready,
  output logic                  pr_err,
  output logic                  pr_stall,
  output logic [NUM_DEV-1:0]    dev_sel,
  output logic [31:0]           dev_addr,
  output logic [31:0]           dev_wd,
  output logic [3:0]            dev_byteen,
  input  logic [32*NUM_DEV-1:0] dev_rd,
  input  logic [NUM_DEV-1:0]    dev_ack
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, state_nx;
  logic [TO_W-1:0]     cnt;
  logic                hit;
  logic [NUM_DEV-1:0]  hit_oh;
  logic [31:0]         rd_sel;
  logic                ack_sel;
  logic                cnt_done;

  // Address decode: first matching window (lowest index) wins.
  always_comb begin
    hit    = 1'b0;
    hit_oh = '0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      if (!hit && ((pr_addr & DEV_MASK[32*i +: 32]) == DEV_BASE[32*i +: 32])) begin
        hit       = 1'b1;
        hit_oh[i] = 1'b1;
      end
    end
  end

  // Read data and ack of the selected device; dev_sel is one-hot, so an
  // AND-OR mux is enough and acks from other devices are masked off.
  always_comb begin
    rd_sel = '0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      if (dev_sel[i]) rd_sel = rd_sel | dev_rd[32*i +: 32];
    end
  end

  assign ack_sel  = |(dev_ack & dev_sel);
  assign cnt_done = (cnt == TO_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nx = state;
    pr_stall = 1'b0;
    pr_ready = 1'b0;
    unique case (state)
      IDLE: begin
        pr_stall = pr_req;
        if (pr_req) state_nx = hit ? ACCESS : RESP;
      end
      ACCESS: begin
        pr_stall = 1'b1;
        if (ack_sel || cnt_done) state_nx = RESP;
      end
      RESP: begin
        pr_ready = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: latch the request, count wait cycles, capture the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      dev_sel    <= '0;
      dev_addr   <= '0;
      dev_wd     <= '0;
      dev_byteen <= '0;
      pr_rd      <= '0;
      pr_err     <= 1'b0;
      cnt        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          pr_rd  <= '0;
          pr_err <= 1'b0;
          if (pr_req) begin
            if (hit) begin
              dev_sel    <= hit_oh;
              dev_addr   <= pr_addr;
              dev_wd     <= pr_wd;
              dev_byteen <= pr_byteen;
              cnt        <= '0;
            end else begin
              pr_err <= 1'b1;
            end
          end
        end
        ACCESS: begin
          // Ack is checked first so it wins over a same-cycle timeout.
          if (ack_sel) begin
            pr_rd      <= (dev_byteen == 4'd0) ? rd_sel : '0;
            pr_err     <= 1'b0;
            dev_sel    <= '0;
            dev_byteen <= '0;
          end else if (cnt_done) begin
            pr_rd      <= '0;
            pr_err     <= 1'b1;
            dev_sel    <= '0;
            dev_byteen <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          pr_rd  <= '0;
          pr_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
